alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-stage front end for the integer ALU datapath (dpath).
- Accepts one decoded ALU micro-op per cycle over a valid/ready handshake.
- Decodes the op into dpath one-hot requests, adds SLT/SLTU/PASS on top of dpath results, and registers the result toward writeback.
- Uses a 2-entry skid buffer so in_ready is a pure register output.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported because dpath is fixed at 32 bits.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  stage clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  upstream micro-op valid
- in_ready  output  1  stage can accept; registered
- in_op  input  4  ALU opcode (see Behaviour)
- in_op1  input  XLEN  operand 1 (rs1 or pc)
- in_op2  input  XLEN  operand 2 (rs2 or imm)
- in_rd  input  RD_W  destination register index
- out_valid  output  1  result valid toward writeback
- out_ready  input  1  writeback accepts
- out_res  output  XLEN  result
- out_rd  output  RD_W  destination index
- out_wen  output  1  out_valid and out_rd != 0
- out_illegal  output  1  opcode was unsupported

Behaviour:
- Clock, reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: in_ready=1; out_valid=0; out_res=0; out_rd=0; out_illegal=0; both skid entries invalid.
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS (result = op2).
  - 11-15 are illegal: result = 0, illegal = 1.
- Decode to dpath (combinational, from input side):
  - req_add for ADD.
  - req_sub for SUB, SLT and SLTU.
  - req_sll, req_srl, req_sra, req_xor, req_or, req_and one-hot per op; all zero for PASS and illegal ops.
  - dpath operands: op1 and op2 wired to all three dpath operand pairs.
  - Shift operand is {27'b0, op2[4:0]}. Upper shift bits are always masked, so a shift by 33 behaves as a shift by 1.
- SLT: lt = (op1[31]^op2[31]) ? op1[31] : diff[31]; result = {31'b0, lt}.
- SLTU: ltu = (op1[31]^op2[31]) ? op2[31] : diff[31].
- diff is the dpath res_addsub output under req_sub.
- Result select: the addsub, shift or logic group is chosen by the opcode, then SLT/SLTU/PASS override.
- Storage: main output register plus one skid register.
- Latency: 1 cycle from accepted input (in_valid & in_ready) to out_valid, when the output register is empty or draining.
- Accept when main is empty or out_ready is high:
  - data goes to main.
  - If main holds data and out_ready is low, data goes to skid instead, and in_ready falls next cycle.
- Drain: when out_ready is high and skid is valid, skid moves into main and in_ready returns to 1 next cycle.
  - Order is preserved strictly; skid is never bypassed.
- Simultaneous accept and drain with skid full cannot occur, because in_ready is 0 while skid is full.
- Once out_valid is raised, out_res, out_rd and out_illegal are held stable until out_ready is high.
- flush:
  - Next edge: both entries are invalidated and in_ready=1.
  - Any input accepted in the flush cycle is discarded.
  - flush takes priority over accept and drain.
- Reset mid-operation: all entries are dropped immediately (asynchronous); data registers return to 0.
- out_wen is 0 whenever out_rd == 0, including for illegal ops.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ALU_ADD..ALU_PASS.
  - ALU_OP_W = 4.
  - result-group select encoding.
- Sub-module: the existing dpath, instantiated once, purely combinational.
- The skid buffer is inline; no further sub-module.

Test Plan:
- Reset then single ops with out_ready=1:
  - ADD 0x7FFFFFFF + 1 gives 0x80000000 one cycle after accept.
  - SUB 5 - 7 gives 0xFFFFFFFE.
- Compare corners:
  - SLT 0x80000000 vs 1 gives 1.
  - SLTU 0x80000000 vs 1 gives 0.
  - SLTU 1 vs 0xFFFFFFFF gives 1.
- Shifts:
  - SRA 0x80000000 by 4 gives 0xF8000000.
  - SRL 0x80000000 by 4 gives 0x08000000.
  - SLL 1 by 33 gives 2 (masking).
- Backpressure:
  - Hold out_ready=0 and issue 3 back-to-back ops (ADD 1+1, XOR 3^5, OR 8|1).
  - in_ready drops after the 2nd accept.
  - Releasing out_ready yields 2, 6, 9 in order with no loss or duplication.
- flush with both entries full:
  - out_valid=0 and in_ready=1 next cycle.
  - An op presented in the flush cycle never appears at the output.
- Opcode 13 with rd=3 gives out_illegal=1, out_res=0, out_wen=1; PASS with rd=0 gives out_wen=0.
- Assert rst_n low while holding data: out_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/alu_pkg.sv
// ==== alu_pkg : opcodes and result-group encoding for alu_exec_stage. rev 1.0 ====
`default_nettype none

package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd10;

  typedef enum logic [1:0] {
    GRP_ADDSUB = 2'd0,
    GRP_SHIFT  = 2'd1,
    GRP_LOGIC  = 2'd2,
    GRP_NONE   = 2'd3
  } grp_sel_e;

endpackage

`default_nettype wire

// File: rtl/dpath.sv
// ==== dpath : combinational 32-bit add/sub, shift and logic units with one-hot requests. rev 1.0 ====
`default_nettype none

module dpath (
  input  logic        req_add,
  input  logic        req_sub,
  input  logic        req_sll,
  input  logic        req_srl,
  input  logic        req_sra,
  input  logic        req_xor,
  input  logic        req_or,
  input  logic        req_and,
  input  logic [31:0] addsub_a,
  input  logic [31:0] addsub_b,
  input  logic [31:0] shift_a,
  input  logic [31:0] shift_b,
  input  logic [31:0] logic_a,
  input  logic [31:0] logic_b,
  output logic [31:0] res_addsub,
  output logic [31:0] res_shift,
  output logic [31:0] res_logic
);

  always_comb begin
    res_addsub = '0;
    if (req_add)      res_addsub = addsub_a + addsub_b;
    else if (req_sub) res_addsub = addsub_a - addsub_b;
  end

  always_comb begin
    res_shift = '0;
    if (req_sll)      res_shift = shift_a << shift_b;
    else if (req_srl) res_shift = shift_a >> shift_b;
    else if (req_sra) res_shift = 32'($signed(shift_a) >>> shift_b);
  end

  always_comb begin
    res_logic = '0;
    if (req_xor)      res_logic = logic_a ^ logic_b;
    else if (req_or)  res_logic = logic_a | logic_b;
    else if (req_and) res_logic = logic_a & logic_b;
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_stage.sv
// ==== alu_exec_stage : ALU execute front end with registered output and 1-deep skid. rev 1.0 ====
`default_nettype none

module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [XLEN-1:0]     in_op1,
  input  logic [XLEN-1:0]     in_op2,
  input  logic [RD_W-1:0]     in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_res,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_wen,
  output logic                out_illegal
);

  logic            w_req_add, w_req_sub, w_req_sll, w_req_srl, w_req_sra;
  logic            w_req_xor, w_req_or, w_req_and, w_illegal;
  grp_sel_e        w_grp;
  logic [XLEN-1:0] w_shamt, w_res_addsub, w_res_shift, w_res_logic, w_result;
  logic            w_lt, w_ltu;

  always_comb begin
    w_req_add = 1'b0; w_req_sub = 1'b0; w_req_sll = 1'b0; w_req_srl = 1'b0;
    w_req_sra = 1'b0; w_req_xor = 1'b0; w_req_or  = 1'b0; w_req_and = 1'b0;
    w_illegal = 1'b0;
    w_grp     = GRP_NONE;
    case (in_op)
      ALU_ADD:                   begin w_req_add = 1'b1; w_grp = GRP_ADDSUB; end
      ALU_SUB, ALU_SLT, ALU_SLTU: begin w_req_sub = 1'b1; w_grp = GRP_ADDSUB; end
      ALU_SLL:                   begin w_req_sll = 1'b1; w_grp = GRP_SHIFT;  end
      ALU_SRL:                   begin w_req_srl = 1'b1; w_grp = GRP_SHIFT;  end
      ALU_SRA:                   begin w_req_sra = 1'b1; w_grp = GRP_SHIFT;  end
      ALU_XOR:                   begin w_req_xor = 1'b1; w_grp = GRP_LOGIC;  end
      ALU_OR:                    begin w_req_or  = 1'b1; w_grp = GRP_LOGIC;  end
      ALU_AND:                   begin w_req_and = 1'b1; w_grp = GRP_LOGIC;  end
      ALU_PASS:                  w_grp = GRP_NONE;
      default:                   w_illegal = 1'b1;
    endcase
  end

  // Only the low five bits of op2 ever reach the shifter.
  assign w_shamt = {{(XLEN-5){1'b0}}, in_op2[4:0]};

  dpath u_dpath (
    .req_add    (w_req_add),
    .req_sub    (w_req_sub),
    .req_sll    (w_req_sll),
    .req_srl    (w_req_srl),
    .req_sra    (w_req_sra),
    .req_xor    (w_req_xor),
    .req_or     (w_req_or),
    .req_and    (w_req_and),
    .addsub_a   (in_op1),
    .addsub_b   (in_op2),
    .shift_a    (in_op1),
    .shift_b    (w_shamt),
    .logic_a    (in_op1),
    .logic_b    (in_op2),
    .res_addsub (w_res_addsub),
    .res_shift  (w_res_shift),
    .res_logic  (w_res_logic)
  );

  assign w_lt  = (in_op1[XLEN-1] ^ in_op2[XLEN-1]) ? in_op1[XLEN-1] : w_res_addsub[XLEN-1];
  assign w_ltu = (in_op1[XLEN-1] ^ in_op2[XLEN-1]) ? in_op2[XLEN-1] : w_res_addsub[XLEN-1];

  always_comb begin
    case (w_grp)
      GRP_ADDSUB: w_result = w_res_addsub;
      GRP_SHIFT:  w_result = w_res_shift;
      GRP_LOGIC:  w_result = w_res_logic;
      default:    w_result = '0;
    endcase
    if (in_op == ALU_SLT)       w_result = {{(XLEN-1){1'b0}}, w_lt};
    else if (in_op == ALU_SLTU) w_result = {{(XLEN-1){1'b0}}, w_ltu};
    else if (in_op == ALU_PASS) w_result = in_op2;
  end

  logic            r_in_ready;
  logic            r_main_valid, r_main_ill, r_skid_valid, r_skid_ill;
  logic [XLEN-1:0] r_main_res, r_skid_res;
  logic [RD_W-1:0] r_main_rd, r_skid_rd;
  logic            w_accept, w_main_free;

  assign w_accept    = in_valid & r_in_ready;
  assign w_main_free = ~r_main_valid | out_ready;

  // in_ready is low exactly while the skid holds data, so accept never meets a full skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b1;
      r_main_valid <= 1'b0;
      r_main_res   <= '0;
      r_main_rd    <= '0;
      r_main_ill   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_res   <= '0;
      r_skid_rd    <= '0;
      r_skid_ill   <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_res   <= r_skid_res;
        r_main_rd    <= r_skid_rd;
        r_main_ill   <= r_skid_ill;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_res   <= w_result;
        r_main_rd    <= in_rd;
        r_main_ill   <= w_illegal;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_res   <= w_result;
      r_skid_rd    <= in_rd;
      r_skid_ill   <= w_illegal;
      r_in_ready   <= 1'b0;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_valid;
  assign out_res     = r_main_res;
  assign out_rd      = r_main_rd;
  assign out_illegal = r_main_ill;
  assign out_wen     = r_main_valid & (|r_main_rd);

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// ==== tb_alu_exec_stage : vector table, directed corner sequences and random scoreboard. rev 1.0 ====
`default_nettype none

module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_wen, out_illegal;
  logic [3:0]  in_op;
  logic [31:0] in_op1, in_op2, out_res;
  logic [4:0]  in_rd, out_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ill;
    logic        wen;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  vec_t vecs[14];
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_rd = rd;
  endtask

  // Returns {illegal, result} straight from the instruction-set meaning of each opcode.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a << (b % 32)};
      4'd3:    return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      4'd4:    return {1'b0, 31'd0, (a < b)};
      4'd5:    return {1'b0, a ^ b};
      4'd6:    return {1'b0, a >> (b % 32)};
      4'd7:    return {1'b0, 32'($signed(a) >>> (b % 32))};
      4'd8:    return {1'b0, a | b};
      4'd9:    return {1'b0, a & b};
      4'd10:   return {1'b0, b};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] m;
    exp_t        e;
    logic        fire_in, fire_out, hold;

    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 5'd1,  32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{4'd1,  32'h00000005, 32'h00000007, 5'd2,  32'hFFFFFFFE, 1'b0, 1'b1};
    vecs[2]  = '{4'd3,  32'h80000000, 32'h00000001, 5'd3,  32'h00000001, 1'b0, 1'b1};
    vecs[3]  = '{4'd4,  32'h80000000, 32'h00000001, 5'd4,  32'h00000000, 1'b0, 1'b1};
    vecs[4]  = '{4'd4,  32'h00000001, 32'hFFFFFFFF, 5'd5,  32'h00000001, 1'b0, 1'b1};
    vecs[5]  = '{4'd7,  32'h80000000, 32'h00000004, 5'd6,  32'hF8000000, 1'b0, 1'b1};
    vecs[6]  = '{4'd6,  32'h80000000, 32'h00000004, 5'd7,  32'h08000000, 1'b0, 1'b1};
    vecs[7]  = '{4'd2,  32'h00000001, 32'h00000021, 5'd8,  32'h00000002, 1'b0, 1'b1};
    vecs[8]  = '{4'd13, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b1, 1'b1};
    vecs[9]  = '{4'd10, 32'hAAAA5555, 32'h00001234, 5'd0,  32'h00001234, 1'b0, 1'b0};
    vecs[10] = '{4'd9,  32'h0000F0F0, 32'h0000FF00, 5'd31, 32'h0000F000, 1'b0, 1'b1};
    vecs[11] = '{4'd3,  32'h00000001, 32'h80000000, 5'd9,  32'h00000000, 1'b0, 1'b1};
    vecs[12] = '{4'd3,  32'hFFFFFFFF, 32'h00000000, 5'd10, 32'h00000001, 1'b0, 1'b1};
    vecs[13] = '{4'd7,  32'h80000000, 32'h00000025, 5'd11, 32'hFC000000, 1'b0, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_op1 = '0; in_op2 = '0; in_rd = '0;
    tick; tick;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_wen", out_wen, 0);

    // Table vectors, issued back to back with writeback always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      tick;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_res", i), out_res, vecs[i].res);
      chk($sformatf("vec%0d_ill", i), out_illegal, vecs[i].ill);
      chk($sformatf("vec%0d_wen", i), out_wen, vecs[i].wen);
      chk($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
    end
    in_valid = 1'b0;
    tick;
    chk("vec_drain_valid", out_valid, 0);

    // Backpressure: three ops against a stalled writeback.
    out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd1, 5'd1);
    tick;
    chk("bp_ready_after1", in_ready, 1);
    drive(4'd5, 32'd3, 32'd5, 5'd2);
    tick;
    chk("bp_ready_after2", in_ready, 0);
    chk("bp_hold_res_a", out_res, 32'd2);
    drive(4'd8, 32'd8, 32'd1, 5'd3);
    tick;
    chk("bp_ready_stall", in_ready, 0);
    chk("bp_hold_res_b", out_res, 32'd2);
    out_ready = 1'b1;
    tick;
    chk("bp_order_2nd", out_res, 32'd6);
    chk("bp_ready_back", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("bp_order_3rd", out_res, 32'd9);
    chk("bp_valid_3rd", out_valid, 1);
    tick;
    chk("bp_empty", out_valid, 0);

    // Flush with both entries full and an op on the input.
    out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd1, 5'd1); tick;
    drive(4'd0, 32'd2, 32'd2, 5'd2); tick;
    drive(4'd10, 32'd0, 32'h0000DEAD, 5'd4);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_full_valid", out_valid, 0);
    chk("fl_full_ready", in_ready, 1);
    out_ready = 1'b1;
    tick;
    chk("fl_full_stay_empty", out_valid, 0);

    // Flush with only the main entry full, so the flush-cycle op would have been accepted.
    out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd1, 5'd1); tick;
    drive(4'd10, 32'd0, 32'h0000BEEF, 5'd5);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_half_valid", out_valid, 0);
    chk("fl_half_ready", in_ready, 1);
    out_ready = 1'b1;
    tick;
    chk("fl_half_stay_empty", out_valid, 0);

    // Asynchronous reset while data is held.
    out_ready = 1'b0;
    drive(4'd0, 32'd3, 32'd4, 5'd6); tick;
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_res", out_res, 0);
    chk("ar_rd", out_rd, 0);
    #2 rst_n = 1'b1;
    tick;
    chk("ar_post_valid", out_valid, 0);

    // Random traffic against a FIFO reference.
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      in_op1    = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      in_op2    = ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd1) : $urandom;
      in_rd     = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 59) == 0);
      chk("rnd_valid", out_valid, (q.size() != 0));
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      hold     = out_valid & ~out_ready & ~flush;
      if (flush) begin
        q.delete();
      end else begin
        if (fire_out && q.size() != 0) begin
          e = q.pop_front();
          chk("rnd_res", out_res, e.res);
          chk("rnd_rd", out_rd, e.rd);
          chk("rnd_ill", out_illegal, e.ill);
          chk("rnd_wen", out_wen, (e.rd != 0));
        end
        if (fire_in) begin
          m = model(in_op, in_op1, in_op2);
          q.push_back('{m[31:0], in_rd, m[32]});
        end
      end
      tick;
      if (hold && q.size() != 0) begin
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_res", out_res, q[0].res);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() != 0; k++) begin
      if (out_valid) begin
        e = q.pop_front();
        chk("rnd_drain_res", out_res, e.res);
      end
      tick;
    end
    chk("rnd_drain_left", q.size(), 0);
    chk("rnd_final_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
